// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared codes for the ALU control stage and its mul/div engine.
// Holds the ALUOp and ALUCtrl encodings, the R-type funct codes
// (including MULT/DIV/MFHI/MFLO/MTHI/MTLO), the engine FSM states,
// and the registered decode function used by the top level.
package alu_ctrl_muldiv_pkg;

    localparam logic [4:0] ALUOp_RTYPE  = 5'h1F;

    localparam logic [4:0] ALUCtrl_ADD  = 5'h01;
    localparam logic [4:0] ALUCtrl_ADDU = 5'h02;
    localparam logic [4:0] ALUCtrl_SUB  = 5'h03;
    localparam logic [4:0] ALUCtrl_SUBU = 5'h04;
    localparam logic [4:0] ALUCtrl_AND  = 5'h05;
    localparam logic [4:0] ALUCtrl_OR   = 5'h06;
    localparam logic [4:0] ALUCtrl_XOR  = 5'h07;
    localparam logic [4:0] ALUCtrl_NOR  = 5'h08;
    localparam logic [4:0] ALUCtrl_SLT  = 5'h09;
    localparam logic [4:0] ALUCtrl_SLTU = 5'h0A;
    localparam logic [4:0] ALUCtrl_SLL  = 5'h0B;
    localparam logic [4:0] ALUCtrl_SRL  = 5'h0C;
    localparam logic [4:0] ALUCtrl_SRA  = 5'h0D;
    localparam logic [4:0] ALUCtrl_SLLV = 5'h0E;
    localparam logic [4:0] ALUCtrl_SRLV = 5'h0F;
    localparam logic [4:0] ALUCtrl_SRAV = 5'h10;
    localparam logic [4:0] ALUCtrl_NOP  = 5'h1E;

    localparam logic [5:0] INSTR_SLL_FUNCT   = 6'h00;
    localparam logic [5:0] INSTR_SRL_FUNCT   = 6'h02;
    localparam logic [5:0] INSTR_SRA_FUNCT   = 6'h03;
    localparam logic [5:0] INSTR_SLLV_FUNCT  = 6'h04;
    localparam logic [5:0] INSTR_SRLV_FUNCT  = 6'h06;
    localparam logic [5:0] INSTR_SRAV_FUNCT  = 6'h07;
    localparam logic [5:0] INSTR_MFHI_FUNCT  = 6'h10;
    localparam logic [5:0] INSTR_MTHI_FUNCT  = 6'h11;
    localparam logic [5:0] INSTR_MFLO_FUNCT  = 6'h12;
    localparam logic [5:0] INSTR_MTLO_FUNCT  = 6'h13;
    localparam logic [5:0] INSTR_MULT_FUNCT  = 6'h18;
    localparam logic [5:0] INSTR_MULTU_FUNCT = 6'h19;
    localparam logic [5:0] INSTR_DIV_FUNCT   = 6'h1A;
    localparam logic [5:0] INSTR_DIVU_FUNCT  = 6'h1B;
    localparam logic [5:0] INSTR_ADD_FUNCT   = 6'h20;
    localparam logic [5:0] INSTR_ADDU_FUNCT  = 6'h21;
    localparam logic [5:0] INSTR_SUB_FUNCT   = 6'h22;
    localparam logic [5:0] INSTR_SUBU_FUNCT  = 6'h23;
    localparam logic [5:0] INSTR_AND_FUNCT   = 6'h24;
    localparam logic [5:0] INSTR_OR_FUNCT    = 6'h25;
    localparam logic [5:0] INSTR_XOR_FUNCT   = 6'h26;
    localparam logic [5:0] INSTR_NOR_FUNCT   = 6'h27;
    localparam logic [5:0] INSTR_SLT_FUNCT   = 6'h2A;
    localparam logic [5:0] INSTR_SLTU_FUNCT  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Funct codes handled by the mul/div engine or the HI/LO registers.
    function automatic logic is_md_funct(input logic [5:0] funct);
        case (funct)
            INSTR_MULT_FUNCT, INSTR_MULTU_FUNCT,
            INSTR_DIV_FUNCT,  INSTR_DIVU_FUNCT,
            INSTR_MFHI_FUNCT, INSTR_MFLO_FUNCT,
            INSTR_MTHI_FUNCT, INSTR_MTLO_FUNCT: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] alu_decode(input logic [4:0] aluop,
                                              input logic [5:0] funct);
        if (aluop != ALUOp_RTYPE) return aluop;
        if (is_md_funct(funct))   return ALUCtrl_NOP;
        case (funct)
            INSTR_ADD_FUNCT:  return ALUCtrl_ADD;
            INSTR_ADDU_FUNCT: return ALUCtrl_ADDU;
            INSTR_SUB_FUNCT:  return ALUCtrl_SUB;
            INSTR_SUBU_FUNCT: return ALUCtrl_SUBU;
            INSTR_AND_FUNCT:  return ALUCtrl_AND;
            INSTR_OR_FUNCT:   return ALUCtrl_OR;
            INSTR_XOR_FUNCT:  return ALUCtrl_XOR;
            INSTR_NOR_FUNCT:  return ALUCtrl_NOR;
            INSTR_SLT_FUNCT:  return ALUCtrl_SLT;
            INSTR_SLTU_FUNCT: return ALUCtrl_SLTU;
            INSTR_SLL_FUNCT:  return ALUCtrl_SLL;
            INSTR_SRL_FUNCT:  return ALUCtrl_SRL;
            INSTR_SRA_FUNCT:  return ALUCtrl_SRA;
            INSTR_SLLV_FUNCT: return ALUCtrl_SLLV;
            INSTR_SRLV_FUNCT: return ALUCtrl_SRLV;
            INSTR_SRAV_FUNCT: return ALUCtrl_SRAV;
            default:          return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// ID->EX bus of the ALU control stage.
// master: upstream side (drives in_valid/ALUOp/Funct/operands/flush).
// slave : alu_ctrl_muldiv (drives ALUCtrl/ctrl_valid/stall/mf_*/busy).
interface alu_ctrl_muldiv_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic [4:0]       ALUOp;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic [4:0]       ALUCtrl;
    logic             ctrl_valid;
    logic             stall;
    logic [WIDTH-1:0] mf_result;
    logic             mf_valid;
    logic             busy;

    modport master (
        output in_valid, ALUOp, Funct, rs_val, rt_val, flush,
        input  ALUCtrl, ctrl_valid, stall, mf_result, mf_valid, busy
    );

    modport slave (
        input  in_valid, ALUOp, Funct, rs_val, rt_val, flush,
        output ALUCtrl, ctrl_valid, stall, mf_result, mf_valid, busy
    );
endinterface

// File: rtl/alu_ctrl_muldiv_muldiv_iter.sv
// Iterative multiply/divide engine: one bit per cycle for WIDTH cycles,
// then one FIX cycle that applies signs and presents the HI/LO result.
// Ports: clk/rst, kill (abort to IDLE), start/is_div/is_signed/a/b
// (sampled in IDLE), busy (not IDLE), done (one-cycle result strobe),
// res_hi/res_lo (valid while done).
module muldiv_iter
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] m_r;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_r;    // partial product high / remainder
    logic [WIDTH-1:0] lo_r;    // multiplier shifting out / quotient shifting in
    logic             div_r, neg_res, neg_rem, dz;

    logic             last;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIX) && !kill;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (start) state_nxt = is_div ? ST_DIV : ST_MUL;
            ST_MUL, ST_DIV: if (last)  state_nxt = ST_FIX;
            ST_FIX:         state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    always_comb begin
        abs_a    = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b    = (is_signed && b[WIDTH-1]) ? -b : b;
        mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
        div_sh   = {hi_r, lo_r[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_r};

        prod = {hi_r, lo_r};
        if (neg_res) prod = -prod;
        quo = neg_res ? -lo_r : lo_r;
        rem = neg_rem ? -hi_r : hi_r;
        // A zero divisor leaves |rs| as remainder; only the quotient is forced.
        if (dz) quo = '1;
        res_hi = div_r ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = div_r ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            m_r     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            div_r   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else if (kill) begin
            cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            cnt     <= '0;
            m_r     <= is_div ? abs_b : abs_a;
            hi_r    <= '0;
            lo_r    <= is_div ? abs_a : abs_b;
            div_r   <= is_div;
            neg_res <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= is_signed && a[WIDTH-1];
            dz      <= is_div && (b == '0);
        end else if (state == ST_MUL) begin
            {hi_r, lo_r} <= {mul_sum, lo_r[WIDTH-1:1]};
            cnt          <= cnt + 1'b1;
        end else if (state == ST_DIV) begin
            if (!div_diff[WIDTH]) begin
                hi_r <= div_diff[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_r <= div_sh[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control stage between ID and EX: registered ALUOp/Funct decode,
// HI/LO registers and the iterative mul/div engine.
// Ports: clk, rst (sync, active-high), bus (slave side of
// alu_ctrl_muldiv_if: inputs in_valid/ALUOp/Funct/rs_val/rt_val/flush,
// outputs ALUCtrl/ctrl_valid/stall/mf_result/mf_valid/busy).
module alu_ctrl_muldiv
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_ctrl_muldiv_if.slave   bus
);
    logic             is_rtype, md_op, accept, start_md, is_div_op, is_signed_op;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] hi, lo, res_hi, res_lo;

    always_comb begin
        is_rtype     = (bus.ALUOp == ALUOp_RTYPE);
        md_op        = is_rtype && is_md_funct(bus.Funct);
        is_div_op    = (bus.Funct == INSTR_DIV_FUNCT)  || (bus.Funct == INSTR_DIVU_FUNCT);
        is_signed_op = (bus.Funct == INSTR_MULT_FUNCT) || (bus.Funct == INSTR_DIV_FUNCT);
        accept       = bus.in_valid && !bus.stall && !bus.flush;
        start_md     = accept && is_rtype &&
                       (is_div_op || (bus.Funct == INSTR_MULT_FUNCT) ||
                        (bus.Funct == INSTR_MULTU_FUNCT));
    end

    // Any HI/LO user waits while the engine is anywhere but IDLE.
    assign bus.stall = bus.in_valid && md_op && md_busy;
    assign bus.busy  = md_busy;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .kill      (bus.flush),
        .start     (start_md),
        .is_div    (is_div_op),
        .is_signed (is_signed_op),
        .a         (bus.rs_val),
        .b         (bus.rt_val),
        .busy      (md_busy),
        .done      (md_done),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ALUCtrl    <= '0;
            bus.ctrl_valid <= 1'b0;
            bus.mf_valid   <= 1'b0;
            bus.mf_result  <= '0;
            hi             <= '0;
            lo             <= '0;
        end else begin
            bus.ctrl_valid <= accept;
            bus.mf_valid   <= accept && is_rtype &&
                              ((bus.Funct == INSTR_MFHI_FUNCT) || (bus.Funct == INSTR_MFLO_FUNCT));
            if (accept) bus.ALUCtrl <= alu_decode(bus.ALUOp, bus.Funct);
            if (md_done) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (accept && is_rtype) begin
                case (bus.Funct)
                    INSTR_MTHI_FUNCT: hi            <= bus.rs_val;
                    INSTR_MTLO_FUNCT: lo            <= bus.rs_val;
                    INSTR_MFHI_FUNCT: bus.mf_result <= hi;
                    INSTR_MFLO_FUNCT: bus.mf_result <= lo;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv: an arithmetic model of HI/LO
// and engine occupancy, a per-cycle compare process, and directed tests
// with literal expectations.
module tb_alu_ctrl_muldiv;
    localparam int W = 32;

    localparam logic [4:0] OP_RTYPE = 5'h1F;
    localparam logic [4:0] C_NOP = 5'h1E, C_ADD = 5'h01, C_AND = 5'h05;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD = 6'h20, F_AND = 6'h24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_muldiv_if #(.WIDTH(W)) bus ();
    alu_ctrl_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_ctrl(input logic [4:0] op, input logic [5:0] fn);
        if (op != OP_RTYPE) return op;
        case (fn)
            6'h20: return 5'h01;  6'h21: return 5'h02;  6'h22: return 5'h03;
            6'h23: return 5'h04;  6'h24: return 5'h05;  6'h25: return 5'h06;
            6'h26: return 5'h07;  6'h27: return 5'h08;  6'h2A: return 5'h09;
            6'h2B: return 5'h0A;  6'h00: return 5'h0B;  6'h02: return 5'h0C;
            6'h03: return 5'h0D;  6'h04: return 5'h0E;  6'h06: return 5'h0F;
            6'h07: return 5'h10;
            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: return C_NOP;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic ref_is_md(input logic [4:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && ((fn >= 6'h10 && fn <= 6'h13) || (fn >= 6'h18 && fn <= 6'h1B));
    endfunction

    task automatic ref_muldiv(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        int                 sq, sr;
        hi = '0; lo = '0;
        case (fn)
            F_MULT: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {hi, lo} = ps;
            end
            F_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                {hi, lo} = pu;
            end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a;
                end else if (fn == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = a; hi = '0;
                end else if (fn == F_DIV) begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    lo = sq; hi = sr;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endtask

    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo, m_mf;
    logic [4:0]  m_ctrl;
    logic        m_cv, m_mfv;
    int          m_left;   // cycles until the pending HI/LO write lands
    logic        live = 1'b0;

    initial begin
        logic stl, acc;
        forever begin
            @(posedge clk);
            stl = bus.in_valid && ref_is_md(bus.ALUOp, bus.Funct) && (m_left > 0);
            acc = bus.in_valid && !stl && !bus.flush;
            if (rst) begin
                m_hi = '0; m_lo = '0; m_left = 0; m_cv = 0; m_mfv = 0;
                m_ctrl = '0; m_mf = '0; live = 1'b1;
            end else begin
                if (bus.flush) m_left = 0;
                else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = m_pend_hi; m_lo = m_pend_lo;
                    end
                end
                m_cv  = acc;
                m_mfv = 1'b0;
                if (acc) begin
                    m_ctrl = ref_ctrl(bus.ALUOp, bus.Funct);
                    if (bus.ALUOp == OP_RTYPE) begin
                        case (bus.Funct)
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                ref_muldiv(bus.Funct, bus.rs_val, bus.rt_val, m_pend_hi, m_pend_lo);
                                m_left = W + 1;
                            end
                            F_MTHI: m_hi = bus.rs_val;
                            F_MTLO: m_lo = bus.rs_val;
                            F_MFHI: begin m_mfv = 1'b1; m_mf = m_hi; end
                            F_MFLO: begin m_mfv = 1'b1; m_mf = m_lo; end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (live) begin
                check("busy", bus.busy, (m_left > 0));
                check("stall", bus.stall,
                      bus.in_valid && ref_is_md(bus.ALUOp, bus.Funct) && (m_left > 0));
                check("ctrl_valid", bus.ctrl_valid, m_cv);
                if (m_cv) check("ALUCtrl", bus.ALUCtrl, m_ctrl);
                check("mf_valid", bus.mf_valid, m_mfv);
                if (m_mfv) check("mf_result", bus.mf_result, m_mf);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [4:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, output int stalls);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.ALUOp = op; bus.Funct = fn;
        bus.rs_val = a; bus.rt_val = b;
        stalls = 0;
        #1;
        while (bus.stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 200) check("stall bound", 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic rd(input logic [5:0] fn, input logic [31:0] exp, input string name);
        int s;
        issue(OP_RTYPE, fn, 32'h0, 32'h0, s);
        check({name, " mf_valid"}, bus.mf_valid, 1'b1);
        check(name, bus.mf_result, exp);
    endtask

    initial begin
        int s, tot;
        logic [5:0] fn_tab [6];
        logic [4:0] cd_tab [6];
        fn_tab = '{6'h22, 6'h2B, 6'h03, 6'h27, 6'h04, 6'h26};
        cd_tab = '{5'h03, 5'h0A, 5'h0D, 5'h08, 5'h0E, 5'h07};

        bus.in_valid = 0; bus.ALUOp = 0; bus.Funct = 0;
        bus.rs_val = 0; bus.rt_val = 0; bus.flush = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ALUCtrl", bus.ALUCtrl, 5'h00);
        check("reset ctrl_valid", bus.ctrl_valid, 1'b0);
        check("reset mf_result", bus.mf_result, 32'h0);
        check("reset busy", bus.busy, 1'b0);

        // 1: decode
        issue(OP_RTYPE, F_ADD, 32'd1, 32'd2, s);
        check("ADD ctrl_valid", bus.ctrl_valid, 1'b1);
        check("ADD ALUCtrl", bus.ALUCtrl, C_ADD);
        issue(OP_RTYPE, 6'h3F, 32'd0, 32'd0, s);
        check("unknown funct", bus.ALUCtrl, 5'h00);
        issue(5'h05, 6'h00, 32'd0, 32'd0, s);
        check("non-rtype passthrough", bus.ALUCtrl, 5'h05);
        for (int i = 0; i < 6; i++) begin
            issue(OP_RTYPE, fn_tab[i], 32'd0, 32'd0, s);
            check("rtype table", bus.ALUCtrl, cd_tab[i]);
        end
        idle(1);

        // 2: MULT -3*7 then MFLO right behind it
        issue(OP_RTYPE, F_MULT, -32'sd3, 32'd7, s);
        check("MULT ALUCtrl NOP", bus.ALUCtrl, C_NOP);
        check("MULT busy", bus.busy, 1'b1);
        issue(OP_RTYPE, F_MFLO, 32'd0, 32'd0, s);
        check("MFLO stall cycles", s, W + 1);
        check("MFLO mf_valid", bus.mf_valid, 1'b1);
        check("MULT LO", bus.mf_result, 32'hFFFF_FFEB);
        check("model LO", m_lo, 32'hFFFF_FFEB);
        rd(F_MFHI, 32'hFFFF_FFFF, "MULT HI");

        // 3: divides, including zero divisor and signed overflow
        issue(OP_RTYPE, F_DIV, -32'sd7, 32'd2, s);
        rd(F_MFLO, 32'hFFFF_FFFD, "DIV LO");
        rd(F_MFHI, 32'hFFFF_FFFF, "DIV HI");
        issue(OP_RTYPE, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
        rd(F_MFLO, 32'h8000_0000, "DIV ovf LO");
        rd(F_MFHI, 32'h0, "DIV ovf HI");
        issue(OP_RTYPE, F_DIV, -32'sd7, 32'd0, s);
        rd(F_MFLO, 32'hFFFF_FFFF, "DIV /0 LO");
        rd(F_MFHI, 32'hFFFF_FFF9, "DIV /0 HI");
        issue(OP_RTYPE, F_DIVU, 32'd7, 32'd0, s);
        rd(F_MFLO, 32'hFFFF_FFFF, "DIVU /0 LO");
        rd(F_MFHI, 32'h7, "DIVU /0 HI");

        // 4: flush a running DIVU
        issue(OP_RTYPE, F_DIVU, 32'd100, 32'd7, s);
        idle(4);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush busy", bus.busy, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        rd(F_MFHI, 32'h7, "flush old HI");
        rd(F_MFLO, 32'hFFFF_FFFF, "flush old LO");

        // 5: MULTU with ALU ops streaming behind it
        issue(OP_RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        tot = 0;
        for (int i = 0; i < 40; i++) begin
            issue(OP_RTYPE, F_AND, i, i, s);
            tot += s;
        end
        check("AND stalls", tot, 0);
        check("AND ALUCtrl", bus.ALUCtrl, C_AND);
        rd(F_MFHI, 32'hFFFF_FFFE, "MULTU HI");
        rd(F_MFLO, 32'h0000_0001, "MULTU LO");

        // 6: reset mid-DIV, then MTHI
        issue(OP_RTYPE, F_DIV, 32'd1000, 32'd3, s);
        idle(10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst busy", bus.busy, 1'b0);
        issue(OP_RTYPE, F_MTHI, 32'h1234, 32'd0, s);
        check("MTHI stalls", s, 0);
        rd(F_MFHI, 32'h1234, "MTHI HI");
        rd(F_MFLO, 32'h0, "rst LO");
        issue(OP_RTYPE, F_MTLO, 32'hBEEF, 32'd0, s);
        rd(F_MFLO, 32'hBEEF, "MTLO LO");
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
